input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  N-channel conditioner for the board's mechanical inputs (KEY, SW) ahead of the CPU's memory-mapped I/O.
//  Per channel: synchroniser, polarity fix, debounce, press/release pulses, optional auto-repeat,
//  and a sticky change bitmap the CPU reads and clears.
// PARAMETERS
//  NUM_CH          14       channel count (KEY[3:0] + SW[9:0])
//  SYNC_STAGES     2        synchroniser flops per channel, >=2
//  DEBOUNCE_CYCLES 500000   cycles input must stay stable before acceptance (10 ms @ 50 MHz), >=1
//  INVERT_MASK     'hF      bit=1: channel is active-low at the pin, inverted after sync
//  REPEAT_MASK     'h0      bit=1: channel auto-repeats while held
//  REPEAT_DELAY    25000000 cycles from accepted press to first repeat pulse, >=1
//  REPEAT_PERIOD   5000000  cycles between subsequent repeat pulses, >=1
// PORTS
//  clock          in   1       system clock
//  reset_n        in   1       asynchronous reset, active low
//  raw_in         in   NUM_CH  unsynchronised pin levels
//  state_out      out  NUM_CH  debounced level, 1 = active
//  press_pulse    out  NUM_CH  1-cycle pulse on accepted 0->1
//  release_pulse  out  NUM_CH  1-cycle pulse on accepted 1->0
//  repeat_pulse   out  NUM_CH  1-cycle auto-repeat pulse (REPEAT_MASK channels only)
//  changed        out  NUM_CH  sticky: set by press/release/repeat pulse
//  changed_clr    in   NUM_CH  write-1-to-clear for changed
//  irq            out  1       |changed, registered
// BEHAVIOUR
//  Reset: all sync flops at inactive level (post-inversion 0); every output, counter and FSM at 0 / IDLE.
//  Sync: raw_in -> SYNC_STAGES flops -> XOR INVERT_MASK = s[i].
//  Debounce: cnt width $clog2(DEBOUNCE_CYCLES+1). s==state_out -> cnt<=0. Else cnt++;
//   on cnt==DEBOUNCE_CYCLES-1 -> state_out toggles, cnt<=0, press/release pulse asserted same cycle.
//   Any bounce back before terminal count restarts cnt from 0; no partial credit.
//  Latency: clean raw edge -> state_out and pulse = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
//  Repeat FSM per REPEAT_MASK channel, counter rcnt sized for max(REPEAT_DELAY,REPEAT_PERIOD):
//   IDLE  : press_pulse -> DELAY, rcnt<=0.
//   DELAY : rcnt==REPEAT_DELAY-1 -> repeat_pulse, rcnt<=0, -> RPT; else rcnt++.
//   RPT   : rcnt==REPEAT_PERIOD-1 -> repeat_pulse, rcnt<=0; else rcnt++.
//   DELAY/RPT: release_pulse -> IDLE; release has priority, no repeat_pulse that cycle.
//   Non-masked channels: FSM tied IDLE, repeat_pulse constant 0.
//  changed[i] <= (changed[i] & ~changed_clr[i]) | pulse_any[i]; set wins over simultaneous clear.
//  irq registered from changed: one cycle after changed rises/falls.
//  Pin held active at reset release: press reported after normal latency (no suppression).
//  Reset mid-debounce or mid-repeat: immediate return to reset state, no pulses emitted.
//  Channels fully independent; simultaneous events on many channels all reported same cycle.
// STRUCTURE
//  Package falcon_io_pkg: rpt_state_t enum {RPT_IDLE, RPT_DELAY, RPT_RUN}; KEY/SW channel index constants.
//  Sub-module input_channel (one sync+debounce+repeat lane); input_conditioner = generate loop
//  over NUM_CH + changed/irq logic. Mask bits passed to lanes as 1-bit parameters.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=4, INVERT_MASK='h1, REPEAT_MASK='h2)
//  Reset: reset_n=0 with raw_in=all 1s -> all outputs 0; release; ch0 (active-low, inactive) quiet, ch1.. press at +6 cycles.
//  Clean press ch2 0->1 at cycle T -> state_out[2]=1 and press_pulse[2] 1 cycle at T+6; release likewise -> release_pulse.
//  Bounce ch2 toggling every 2 cycles for 20 cycles then stable 1 -> exactly one press_pulse, 6 cycles after last edge.
//  Auto-repeat ch1 held -> press at T+6, repeat at T+16, T+20, T+24; release -> release_pulse, no further repeats.
//  changed_clr[3] asserted in same cycle as press_pulse[3] -> changed[3] stays 1; later clr alone -> 0, irq falls 1 cycle later.
//  reset_n pulsed low during DELAY on ch1 -> all outputs 0 asynchronously; no repeat_pulse after release of reset.

Source files
------------

// File: rtl/falcon_io_pkg.sv
// Shared types and constants for the board input conditioner.
//   rpt_state_t : per-lane auto-repeat state
//   KEY/SW      : channel layout of the board's push buttons and slide switches
package falcon_io_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } rpt_state_t;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned NUM_SW   = 10;
  localparam int unsigned KEY_BASE = 0;
  localparam int unsigned SW_BASE  = KEY_BASE + NUM_KEYS;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioning lane: synchroniser, polarity fix, debounce, edge pulses, auto-repeat.
// Ports:
//   clock, reset_n   : clock and async active-low reset
//   raw_in           : unsynchronised pin level
//   state_out        : debounced level, 1 = active
//   press_pulse      : 1-cycle pulse on accepted 0->1
//   release_pulse    : 1-cycle pulse on accepted 1->0
//   repeat_pulse     : 1-cycle auto-repeat pulse while held (REPEAT_EN lanes only)
module input_channel
  import falcon_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          INVERT          = 1'b0,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  output logic state_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned RCNT_W  = $clog2(RPT_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  rpt_state_t             rpt_state_q, rpt_state_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;
  logic                   s;
  logic                   press_ev, release_ev;

  // Synchronised level with pin polarity removed.
  assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

  // Debounce and repeat next-state; the repeat FSM reacts to the same-cycle
  // acceptance event so its delay is measured from the press pulse itself.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d       = cnt_q;
    level_d     = level_q;
    rcnt_d      = rcnt_q;
    rpt_state_d = rpt_state_q;
    press_ev    = 1'b0;
    release_ev  = 1'b0;
    repeat_d    = 1'b0;

    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d    = s;
      cnt_d      = '0;
      press_ev   = s;
      release_ev = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    press_d   = press_ev;
    release_d = release_ev;

    if (REPEAT_EN) begin
      case (rpt_state_q)
        RPT_IDLE: begin
          if (press_ev) begin
            rpt_state_d = RPT_DELAY;
            rcnt_d      = '0;
          end
        end
        RPT_DELAY: begin
          if (release_ev) begin
            rpt_state_d = RPT_IDLE;
            rcnt_d      = '0;
          end else if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
            repeat_d    = 1'b1;
            rcnt_d      = '0;
            rpt_state_d = RPT_RUN;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        RPT_RUN: begin
          if (release_ev) begin
            rpt_state_d = RPT_IDLE;
            rcnt_d      = '0;
          end else if (rcnt_q == RCNT_W'(REPEAT_PERIOD - 1)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          rpt_state_d = RPT_IDLE;
          rcnt_d      = '0;
        end
      endcase
    end
  end

  // Sync flops reset to the pin's inactive level so nothing fires out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= {SYNC_STAGES{INVERT}};
      cnt_q       <= '0;
      rcnt_q      <= '0;
      rpt_state_q <= RPT_IDLE;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      rpt_state_q <= rpt_state_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign state_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel conditioner for KEY/SW inputs feeding CPU memory-mapped I/O.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   raw_in         : unsynchronised pin levels
//   state_out      : debounced levels, 1 = active
//   press_pulse    : accepted 0->1 pulses
//   release_pulse  : accepted 1->0 pulses
//   repeat_pulse   : auto-repeat pulses
//   changed        : sticky event bitmap
//   changed_clr    : write-1-to-clear for changed
//   irq            : registered OR of changed
module input_conditioner
  import falcon_io_pkg::*;
#(
  parameter int unsigned       NUM_CH          = SW_BASE + NUM_SW,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = NUM_CH'('hF),
  parameter logic [NUM_CH-1:0] REPEAT_MASK     = '0,
  parameter int unsigned       REPEAT_DELAY    = 25000000,
  parameter int unsigned       REPEAT_PERIOD   = 5000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] state_out,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic [NUM_CH-1:0] changed,
  input  logic [NUM_CH-1:0] changed_clr,
  output logic              irq
);

  logic [NUM_CH-1:0] pulse_any;
  logic [NUM_CH-1:0] changed_q, changed_d;
  logic              irq_q, irq_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .INVERT         (INVERT_MASK[i]),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_lane (
      .clock        (clock),
      .reset_n      (reset_n),
      .raw_in       (raw_in[i]),
      .state_out    (state_out[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign pulse_any = press_pulse | release_pulse | repeat_pulse;

  // Sticky change bits: a new event beats a simultaneous clear.
  always_comb begin
    changed_d = (changed_q & ~changed_clr) | pulse_any;
    irq_d     = |changed_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      changed_q <= changed_d;
      irq_q     <= irq_d;
    end
  end

  assign changed = changed_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat timing.
module tb_input_conditioner;
  import falcon_io_pkg::*;

  localparam int unsigned NCH    = SW_BASE + NUM_SW;
  localparam int unsigned CH_AL  = KEY_BASE;
  localparam int unsigned CH_RPT = KEY_BASE + 1;
  localparam int unsigned CH_B   = KEY_BASE + 2;

  logic           clock;
  logic           reset_n;
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] state_out, press_pulse, release_pulse, repeat_pulse, changed;
  logic [NCH-1:0] changed_clr;
  logic           irq;

  int n_total = 0;
  int n_pass  = 0;

  input_conditioner #(
    .NUM_CH         (NCH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .INVERT_MASK    (14'h0001),
    .REPEAT_MASK    (14'h0002),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .state_out    (state_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .changed      (changed),
    .changed_clr  (changed_clr),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string          name;
    int             adv;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] st;
    logic [NCH-1:0] pr;
    logic [NCH-1:0] rl;
    logic [NCH-1:0] rp;
    logic [NCH-1:0] ch;
    logic           irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input int adv,
                              input logic [NCH-1:0] raw, input logic [NCH-1:0] clr,
                              input logic [NCH-1:0] st, input logic [NCH-1:0] pr,
                              input logic [NCH-1:0] rl, input logic [NCH-1:0] rp,
                              input logic [NCH-1:0] ch, input logic irq_e);
    vec_t v;
    v.name = name; v.adv = adv; v.raw = raw; v.clr = clr;
    v.st = st; v.pr = pr; v.rl = rl; v.rp = rp; v.ch = ch; v.irq = irq_e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [NCH-1:0] st, input logic [NCH-1:0] pr,
                         input logic [NCH-1:0] rl, input logic [NCH-1:0] rp,
                         input logic [NCH-1:0] ch, input logic irq_e);
    chk({name, ".state"},   64'(state_out),     64'(st));
    chk({name, ".press"},   64'(press_pulse),   64'(pr));
    chk({name, ".release"}, 64'(release_pulse), 64'(rl));
    chk({name, ".repeat"},  64'(repeat_pulse),  64'(rp));
    chk({name, ".changed"}, 64'(changed),       64'(ch));
    chk({name, ".irq"},     64'(irq),           64'(irq_e));
  endtask

  task automatic clear_all();
    changed_clr = '1;
    step();
    step();
    changed_clr = '0;
    step();
    step();
  endtask

  initial begin
    int             presses;
    int             pr_at;
    int             rel_at;
    logic [63:0]    rpt_seen;
    logic [63:0]    rpt_exp;
    logic [NCH-1:0] any_acc;
    logic [NCH-1:0] rpt_acc;

    //   name           adv raw       clr       st        pr        rl        rp  ch        irq
    add("rst_m1",        5, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 0);
    add("rst_press",     1, 14'h3FFF, 14'h0000, 14'h3FFE, 14'h3FFE, 14'h0000, '0, 14'h0000, 0);
    add("rst_chg",       1, 14'h3FFF, 14'h0000, 14'h3FFE, 14'h0000, 14'h0000, '0, 14'h3FFE, 0);
    add("rst_irq",       1, 14'h3FFF, 14'h0000, 14'h3FFE, 14'h0000, 14'h0000, '0, 14'h3FFE, 1);
    add("relall_m1",     5, 14'h0001, 14'h0000, 14'h3FFE, 14'h0000, 14'h0000, '0, 14'h3FFE, 1);
    add("relall",        1, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h3FFE, '0, 14'h3FFE, 1);
    add("clr_vs_rel",    1, 14'h0001, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, '0, 14'h3FFE, 1);
    add("clr_all",       1, 14'h0001, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 1);
    add("irq_fall",      1, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 0);
    add("ch2_press_m1",  5, 14'h0005, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 0);
    add("ch2_press",     1, 14'h0005, 14'h0000, 14'h0004, 14'h0004, 14'h0000, '0, 14'h0000, 0);
    add("ch2_chg",       1, 14'h0005, 14'h0000, 14'h0004, 14'h0000, 14'h0000, '0, 14'h0004, 0);
    add("ch2_irq",       1, 14'h0005, 14'h0000, 14'h0004, 14'h0000, 14'h0000, '0, 14'h0004, 1);
    add("ch2_rel_m1",    5, 14'h0001, 14'h0000, 14'h0004, 14'h0000, 14'h0000, '0, 14'h0004, 1);
    add("ch2_rel",       1, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0004, '0, 14'h0004, 1);
    add("ch3_press_m1",  5, 14'h0009, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0004, 1);
    add("ch3_press",     1, 14'h0009, 14'h0000, 14'h0008, 14'h0008, 14'h0000, '0, 14'h0004, 1);
    add("ch3_set_wins",  1, 14'h0009, 14'h000C, 14'h0008, 14'h0000, 14'h0000, '0, 14'h0008, 1);
    add("ch3_hold",      1, 14'h0009, 14'h0000, 14'h0008, 14'h0000, 14'h0000, '0, 14'h0008, 1);
    add("ch3_clr",       1, 14'h0009, 14'h0008, 14'h0008, 14'h0000, 14'h0000, '0, 14'h0000, 1);
    add("ch3_irq_fall",  1, 14'h0009, 14'h0000, 14'h0008, 14'h0000, 14'h0000, '0, 14'h0000, 0);
    add("ch3_rel",       6, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0008, '0, 14'h0000, 0);
    add("ch3_rel_chg",   1, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0008, 0);
    add("ch3_rel_clr",   1, 14'h0001, 14'h0008, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 1);
    add("ch3_quiet",     1, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 0);
    add("ch0_al_press",  6, 14'h0000, 14'h0000, 14'h0001, 14'h0001, 14'h0000, '0, 14'h0000, 0);
    add("ch0_al_rel",    6, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0001, '0, 14'h0001, 1);
    add("ch0_set_wins",  1, 14'h0001, 14'h0001, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0001, 1);
    add("ch0_clr",       1, 14'h0001, 14'h0001, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 1);
    add("ch0_quiet",     1, 14'h0001, 14'h0000, 14'h0000, 14'h0000, 14'h0000, '0, 14'h0000, 0);

    // Reset with every pin driven high.
    reset_n     = 1'b0;
    raw_in      = '1;
    changed_clr = '0;
    step();
    step();
    chk_all("in_reset", '0, '0, '0, '0, '0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      raw_in      = vecs[k].raw;
      changed_clr = vecs[k].clr;
      for (int c = 0; c < vecs[k].adv; c++) step();
      chk_all(vecs[k].name, vecs[k].st, vecs[k].pr, vecs[k].rl, vecs[k].rp, vecs[k].ch, vecs[k].irq);
    end
    changed_clr = '0;

    // Bounce on ch2: 2-cycle runs never reach the terminal count.
    presses = 0;
    for (int k = 0; k < 20; k++) begin
      raw_in[CH_B] = (((k / 2) % 2) == 0);
      step();
      if (press_pulse[CH_B]) presses++;
    end
    raw_in[CH_B] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (press_pulse[CH_B]) presses++;
    end
    chk("bounce_no_early_press", 64'(presses), 64'd0);
    chk("bounce_state_early", 64'(state_out[CH_B]), 64'd0);
    step();
    if (press_pulse[CH_B]) presses++;
    chk("bounce_press_at_6", 64'(press_pulse[CH_B]), 64'd1);
    chk("bounce_state", 64'(state_out[CH_B]), 64'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (press_pulse[CH_B]) presses++;
    end
    chk("bounce_one_press", 64'(presses), 64'd1);
    raw_in[CH_B] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    clear_all();
    chk("bounce_cleanup_changed", 64'(changed), 64'd0);

    // Auto-repeat on ch1; release lands on a repeat slot and must win.
    pr_at    = -1;
    rel_at   = -1;
    rpt_seen = '0;
    raw_in[CH_RPT] = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      if (c == 27) raw_in[CH_RPT] = 1'b0;
      step();
      if (press_pulse[CH_RPT])   pr_at = c;
      if (release_pulse[CH_RPT]) rel_at = c;
      if (repeat_pulse[CH_RPT])  rpt_seen[c] = 1'b1;
    end
    rpt_exp = (64'd1 << 16) | (64'd1 << 20) | (64'd1 << 24) | (64'd1 << 28);
    chk("rpt_press_cycle", 64'(pr_at), 64'd6);
    chk("rpt_pulse_cycles", rpt_seen, rpt_exp);
    chk("rpt_release_cycle", 64'(rel_at), 64'd32);
    clear_all();
    chk("rpt_cleanup_irq", 64'(irq), 64'd0);

    // Reset during the repeat delay: outputs drop at once, nothing follows.
    raw_in[CH_RPT] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("rstd_press", 64'(press_pulse[CH_RPT]), 64'd1);
    for (int k = 0; k < 3; k++) step();
    chk("rstd_held", 64'(state_out[CH_RPT]), 64'd1);
    chk("rstd_changed", 64'(changed[CH_RPT]), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all("rstd_async", '0, '0, '0, '0, '0, 1'b0);
    raw_in[CH_RPT] = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    any_acc = '0;
    rpt_acc = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      any_acc = any_acc | state_out | press_pulse | release_pulse | repeat_pulse | changed
                | {{(NCH-1){1'b0}}, irq};
      rpt_acc = rpt_acc | repeat_pulse;
    end
    chk("rstd_no_repeat", 64'(rpt_acc), 64'd0);
    chk("rstd_quiet", 64'(any_acc), 64'd0);
    chk("rstd_ch0_inactive", 64'(state_out[CH_AL]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
